// File: rtl/watchdog_gate_gen_if.sv
// Heartbeat generator bus: IAGC status/hold in,
// gate pulse, active flag and pulse count out.
interface watchdog_gate_gen_if #(
  parameter int STATUS_SIZE = 4,
  parameter int COUNT_WIDTH = 8
);
  logic [STATUS_SIZE-1:0] i_iagcStatus;
  logic                   i_hold;
  logic                   o_gate;
  logic                   o_active;
  logic [COUNT_WIDTH-1:0] o_pulseCount;

  modport master (
    output i_iagcStatus,
    output i_hold,
    input  o_gate,
    input  o_active,
    input  o_pulseCount
  );

  modport slave (
    input  i_iagcStatus,
    input  i_hold,
    output o_gate,
    output o_active,
    output o_pulseCount
  );
endinterface

// File: rtl/watchdog_gate_gen.sv
// Periodic heartbeat source for the IAGC watchdog gate input.
// Fixed-width pulses at a fixed period once IAGC leaves RESET/INIT.
module watchdog_gate_gen #(
  parameter int IAGC_STATUS_SIZE = 4,
  parameter logic [IAGC_STATUS_SIZE-1:0] IAGC_STATUS_RESET = 4'b0000,
  parameter logic [IAGC_STATUS_SIZE-1:0] IAGC_STATUS_INIT  = 4'b0001,
  parameter int HIGH_TICKS   = 2,
  parameter int PERIOD_TICKS = 10,
  parameter int START_DELAY  = 3,
  parameter int COUNT_WIDTH  = 8
) (
  input logic i_clock,
  input logic i_reset,
  watchdog_gate_gen_if.slave bus
);

  localparam int MAXT = (PERIOD_TICKS > START_DELAY)
                      ? PERIOD_TICKS : START_DELAY;
  localparam int CW = (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [CW-1:0] HI_LAST  = CW'(HIGH_TICKS - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(PERIOD_TICKS - 1);
  localparam logic [CW-1:0] DLY_LAST =
    CW'((START_DELAY > 0) ? START_DELAY - 1 : 0);
  localparam bit NO_DELAY = (START_DELAY == 0);

  typedef enum logic [1:0] {
    S_OFF,
    S_DELAY,
    S_HIGH,
    S_LOW
  } state_t;

  state_t                 state;
  logic [CW-1:0]          tick;
  logic                   gate;
  logic                   active;
  logic [COUNT_WIDTH-1:0] count;
  logic                   enable;
  logic                   due;
  logic                   go;

  assign enable = (bus.i_iagcStatus != IAGC_STATUS_RESET)
               && (bus.i_iagcStatus != IAGC_STATUS_INIT);

  // A pulse is due at the end of delay/low, or on enable with no delay
  always_comb begin
    due = 1'b0;
    unique case (state)
      S_OFF:   due = NO_DELAY;
      S_DELAY: due = (tick == DLY_LAST);
      S_LOW:   due = (tick == PER_LAST);
      default: due = 1'b0;
    endcase
    go = enable && due && !bus.i_hold;
  end

  // Schedule FSM; disable wins everywhere, hold only defers a due pulse
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state  <= S_OFF;
      tick   <= '0;
      gate   <= 1'b0;
      active <= 1'b0;
      count  <= '0;
    end else if (!enable) begin
      state  <= S_OFF;
      tick   <= '0;
      gate   <= 1'b0;
      active <= 1'b0;
    end else if (go) begin
      state  <= S_HIGH;
      tick   <= '0;
      gate   <= 1'b1;
      active <= 1'b1;
      count  <= count + 1'b1;
    end else begin
      unique case (state)
        S_OFF: begin
          if (!NO_DELAY) begin
            state  <= S_DELAY;
            tick   <= '0;
            active <= 1'b1;
          end
        end
        S_DELAY: begin
          if (tick != DLY_LAST) tick <= tick + 1'b1;
        end
        S_HIGH: begin
          tick <= tick + 1'b1;
          if (tick == HI_LAST) begin
            state <= S_LOW;
            gate  <= 1'b0;
          end
        end
        S_LOW: begin
          if (tick != PER_LAST) tick <= tick + 1'b1;
        end
        default: begin
          state <= S_OFF;
          gate  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_gate       = gate;
  assign bus.o_active     = active;
  assign bus.o_pulseCount = count;

endmodule

// File: tb/tb_watchdog_gate_gen.sv
// Directed bench for watchdog_gate_gen: default instance plus
// a no-delay, 2-bit-count instance for wrap and immediate start.
module tb_watchdog_gate_gen;

  localparam logic [3:0] ST_RST  = 4'b0000;
  localparam logic [3:0] ST_INIT = 4'b0001;
  localparam logic [3:0] ST_IDLE = 4'b0010;
  localparam logic [3:0] ST_OTH  = 4'b0101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  watchdog_gate_gen_if #(.STATUS_SIZE(4), .COUNT_WIDTH(8)) a_if ();
  watchdog_gate_gen_if #(.STATUS_SIZE(4), .COUNT_WIDTH(2)) b_if ();

  watchdog_gate_gen dut_a (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (a_if)
  );

  watchdog_gate_gen #(
    .START_DELAY (0),
    .COUNT_WIDTH (2)
  ) dut_b (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (b_if)
  );

  typedef struct {
    logic [3:0] st;
    logic       hold;
    logic       g;
    logic       a;
    logic [7:0] c;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [3:0] st, input logic h,
                              input logic g, input logic a,
                              input logic [7:0] c, input int n);
    vec_t v;
    v.st = st; v.hold = h; v.g = g; v.a = a; v.c = c;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic gate_of(input bit sel);
    return sel ? b_if.o_gate : a_if.o_gate;
  endfunction

  // Steps until the selected gate is high; n = edges taken
  task automatic wait_rise(input bit sel, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (gate_of(sel) !== 1'b1 && n < 20);
    if (gate_of(sel) !== 1'b1) check("rise_timeout", 0, 1);
  endtask

  int n;
  int bad;

  initial begin
    a_if.i_iagcStatus = ST_INIT;
    a_if.i_hold       = 1'b0;
    b_if.i_iagcStatus = ST_INIT;
    b_if.i_hold       = 1'b0;

    // Test 1 schedule: INIT, then IDLE at E, status change mid-run
    add(ST_INIT, 0, 0, 0, 0, 1);
    add(ST_IDLE, 0, 0, 1, 0, 3);
    add(ST_IDLE, 0, 1, 1, 1, 2);
    add(ST_IDLE, 0, 0, 1, 1, 8);
    add(ST_IDLE, 0, 1, 1, 2, 2);
    add(ST_IDLE, 0, 0, 1, 2, 1);
    add(ST_OTH,  0, 0, 1, 2, 7);
    add(ST_OTH,  0, 1, 1, 3, 1);

    repeat (10) @(posedge clk);
    #1;
    check("rst_gate",   a_if.o_gate, 0);
    check("rst_active", a_if.o_active, 0);
    check("rst_count",  a_if.o_pulseCount, 0);
    rst = 1'b0;
    repeat (9) tick();
    check("init_active", a_if.o_active, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      a_if.i_iagcStatus = tbl[i].st;
      a_if.i_hold       = tbl[i].hold;
      tick();
      check($sformatf("vec%0d_gate", i), a_if.o_gate, tbl[i].g);
      check($sformatf("vec%0d_act", i), a_if.o_active, tbl[i].a);
      check($sformatf("vec%0d_cnt", i), a_if.o_pulseCount, tbl[i].c);
    end

    // Test 2: steady run up to 50 pulses
    for (int i = 0; i < 47; i++) begin
      tick();
      check("steady_high2", a_if.o_gate, 1);
      tick();
      check("steady_fall", a_if.o_gate, 0);
      wait_rise(1'b0, n);
      check("steady_period", 2 + n, 10);
    end
    check("steady_count", a_if.o_pulseCount, 50);

    // Test 3: hold from mid-low for 25 edges
    repeat (5) tick();
    a_if.i_hold = 1'b1;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (a_if.o_gate !== 1'b0) bad++;
    end
    check("hold_no_rise", bad, 0);
    check("hold_count", a_if.o_pulseCount, 50);
    a_if.i_hold = 1'b0;
    tick();
    check("hold_release_rise", a_if.o_gate, 1);
    check("hold_release_cnt", a_if.o_pulseCount, 51);
    a_if.i_hold = 1'b1;
    tick();
    check("hold_mid_pulse", a_if.o_gate, 1);
    a_if.i_hold = 1'b0;
    tick();
    check("hold_mid_fall", a_if.o_gate, 0);
    wait_rise(1'b0, n);
    check("hold_next_period", 2 + n, 10);
    check("hold_next_cnt", a_if.o_pulseCount, 52);

    // Test 4: disable on second high edge, then re-enable
    a_if.i_iagcStatus = ST_RST;
    tick();
    check("dis_gate", a_if.o_gate, 0);
    check("dis_active", a_if.o_active, 0);
    check("dis_count", a_if.o_pulseCount, 52);
    a_if.i_iagcStatus = ST_IDLE;
    tick();
    check("reen_active", a_if.o_active, 1);
    check("reen_gate0", a_if.o_gate, 0);
    tick();
    tick();
    check("reen_gate2", a_if.o_gate, 0);
    tick();
    check("reen_rise", a_if.o_gate, 1);
    check("reen_count", a_if.o_pulseCount, 53);

    // Test 5: async reset mid-pulse
    #3;
    rst = 1'b1;
    #1;
    check("arst_gate", a_if.o_gate, 0);
    check("arst_active", a_if.o_active, 0);
    check("arst_count", a_if.o_pulseCount, 0);
    tick();
    rst = 1'b0;
    tick();
    check("arst_restart_act", a_if.o_active, 1);
    check("arst_restart_g", a_if.o_gate, 0);
    tick();
    tick();
    tick();
    check("arst_first_rise", a_if.o_gate, 1);
    check("arst_first_cnt", a_if.o_pulseCount, 1);

    // Test 6: no start delay, 2-bit count wrap
    check("b_idle_gate", b_if.o_gate, 0);
    b_if.i_iagcStatus = ST_IDLE;
    tick();
    check("b_enable_rise", b_if.o_gate, 1);
    check("b_enable_act", b_if.o_active, 1);
    check("b_cnt1", b_if.o_pulseCount, 1);
    for (int k = 2; k <= 4; k++) begin
      tick();
      tick();
      check("b_fall", b_if.o_gate, 0);
      wait_rise(1'b1, n);
      check("b_period", 2 + n, 10);
      check($sformatf("b_cnt%0d", k), b_if.o_pulseCount, k % 4);
    end
    b_if.i_iagcStatus = ST_INIT;
    tick();
    check("b_dis_gate", b_if.o_gate, 0);
    b_if.i_iagcStatus = ST_IDLE;
    b_if.i_hold       = 1'b1;
    tick();
    tick();
    check("b_hold_gate", b_if.o_gate, 0);
    b_if.i_hold = 1'b0;
    tick();
    check("b_hold_rise", b_if.o_gate, 1);
    check("b_hold_cnt", b_if.o_pulseCount, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
